kws_psum_engine: RTL and testbench

- Parametrised compute controller for the KWS accelerator. It replaces the fixed 64-bit, 4x4-PE top-level control path.
- Functions:
  - deserialises input words from a bit-serial link;
  - launches an array of NUM_PE processing elements and collects their done pulses (sticky);
  - accumulates the PE partial sums sequentially with signed saturation;
  - applies ReLU, selectable at run time;
  - serialises the result MSB-first with a valid strobe.
- Sits between the serial host interface and the PE array / global buffer.

---
 rtl/kws_psum_engine.sv | 165 ++++++++++++++++
 tb/tb_kws_psum_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kws_psum_engine.sv
// KWS accelerator compute controller: serial word loader, PE launch and done collection,
// saturating partial-sum accumulation, optional ReLU and MSB-first serial result output.
module kws_psum_engine #(
  parameter int DATA_W = 64,
  parameter int NUM_PE = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     serial_data_in,
  input  logic                     serial_load_enable,
  output logic [DATA_W-1:0]        load_word,
  output logic                     load_word_valid,
  input  logic                     start_computation,
  input  logic                     relu_bypass,
  output logic                     pe_start,
  input  logic [NUM_PE-1:0]        pe_done,
  input  logic [NUM_PE*DATA_W-1:0] pe_psum,
  output logic                     busy,
  output logic                     serial_data_out,
  output logic                     serial_out_valid,
  output logic                     overflow,
  output logic                     computation_done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_PE  = IDX_W'(NUM_PE - 1);
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, WAIT_PE, ACCUM, ACT, SHIFT, DONE} state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [NUM_PE-1:0] mask;
  logic [NUM_PE-1:0] mask_next;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] psum_sel;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W-1:0] acc_sat;
  logic              sat_hit;
  logic              start_ok;
  logic              ser_active;

  // Done pulses arriving alongside pe_start belong to the previous launch and are dropped.
  always_comb begin
    ser_active = (state == IDLE) || (state == DONE);
    start_ok   = start_computation && ser_active;
    mask_next  = mask | (pe_start ? '0 : pe_done);
    psum_sel   = pe_psum[int'(idx)*DATA_W +: DATA_W];
    sum_ext    = {acc[DATA_W-1], acc} + {psum_sel[DATA_W-1], psum_sel};
    sat_hit    = sum_ext[DATA_W] != sum_ext[DATA_W-1];
    acc_sat    = sat_hit ? (sum_ext[DATA_W] ? SAT_MIN : SAT_MAX) : sum_ext[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state       = state;
    busy             = 1'b0;
    serial_out_valid = 1'b0;
    serial_data_out  = 1'b0;
    computation_done = 1'b0;
    case (state)
      IDLE: begin
        if (start_computation) next_state = WAIT_PE;
      end
      WAIT_PE: begin
        busy = 1'b1;
        if (&mask_next) next_state = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (idx == LAST_PE) next_state = ACT;
      end
      ACT: begin
        busy       = 1'b1;
        next_state = SHIFT;
      end
      SHIFT: begin
        busy             = 1'b1;
        serial_out_valid = 1'b1;
        serial_data_out  = result[DATA_W-1];
        if (out_cnt == LAST_BIT) next_state = DONE;
      end
      DONE: begin
        computation_done = 1'b1;
        if (start_computation) next_state = WAIT_PE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The word is captured including the bit arriving in the completing cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg       <= '0;
      bit_cnt         <= '0;
      load_word       <= '0;
      load_word_valid <= 1'b0;
    end else begin
      load_word_valid <= 1'b0;
      if (ser_active && serial_load_enable) begin
        shift_reg <= {shift_reg[DATA_W-2:0], serial_data_in};
        if (bit_cnt == LAST_BIT) begin
          load_word       <= {shift_reg[DATA_W-2:0], serial_data_in};
          load_word_valid <= 1'b1;
          bit_cnt         <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pe_start <= 1'b0;
      mask     <= '0;
      idx      <= '0;
      acc      <= '0;
      overflow <= 1'b0;
      result   <= '0;
      out_cnt  <= '0;
    end else begin
      pe_start <= start_ok;
      if (start_ok) begin
        mask     <= '0;
        acc      <= '0;
        overflow <= 1'b0;
        idx      <= '0;
      end
      case (state)
        WAIT_PE: begin
          mask <= mask_next;
          idx  <= '0;
        end
        ACCUM: begin
          acc <= acc_sat;
          if (sat_hit) overflow <= 1'b1;
          idx <= (idx == LAST_PE) ? '0 : idx + 1'b1;
        end
        ACT: begin
          result  <= (!relu_bypass && acc[DATA_W-1]) ? '0 : acc;
          out_cnt <= '0;
        end
        SHIFT: begin
          result  <= {result[DATA_W-2:0], 1'b0};
          out_cnt <= out_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kws_psum_engine.sv
// Scoreboard bench for kws_psum_engine (DATA_W=16, NUM_PE=4): directed vectors, queued
// expectations, and monitors that check loaded words and serial results as they appear.
module tb_kws_psum_engine;

  localparam int DW = 16;
  localparam int NP = 4;

  logic          clk;
  logic          reset_n;
  logic          serial_data_in;
  logic          serial_load_enable;
  logic [DW-1:0] load_word;
  logic          load_word_valid;
  logic          start_computation;
  logic          relu_bypass;
  logic          pe_start;
  logic [NP-1:0] pe_done;
  logic [NP*DW-1:0] pe_psum;
  logic          busy;
  logic          serial_data_out;
  logic          serial_out_valid;
  logic          overflow;
  logic          computation_done;

  kws_psum_engine #(.DATA_W(DW), .NUM_PE(NP)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .serial_data_in(serial_data_in),
    .serial_load_enable(serial_load_enable),
    .load_word(load_word),
    .load_word_valid(load_word_valid),
    .start_computation(start_computation),
    .relu_bypass(relu_bypass),
    .pe_start(pe_start),
    .pe_done(pe_done),
    .pe_psum(pe_psum),
    .busy(busy),
    .serial_data_out(serial_data_out),
    .serial_out_valid(serial_out_valid),
    .overflow(overflow),
    .computation_done(computation_done)
  );

  typedef struct {
    logic [DW-1:0] word;
    logic          ovf;
  } exp_t;

  exp_t          res_q[$];
  logic [DW-1:0] lw_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lw_pulses = 0;
  int pe_start_cnt = 0;
  logic [DW-1:0] mon_sh = '0;
  int mon_bits = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares loaded words and assembled serial results against the queues.
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_bits = 0;
    end else begin
      if (pe_start) pe_start_cnt++;
      if (load_word_valid) begin
        lw_pulses++;
        if (lw_q.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected load_word_valid: got 0x%0h, expected no pulse", load_word);
        end else begin
          check_output("load_word", load_word, lw_q.pop_front());
        end
      end
      if (serial_out_valid) begin
        mon_sh = {mon_sh[DW-2:0], serial_data_out};
        mon_bits++;
        if (mon_bits == DW) begin
          mon_bits = 0;
          if (res_q.size() == 0) begin
            tests++; fails++;
            $display("[TB] FAIL unexpected serial result: got 0x%0h, expected none", mon_sh);
          end else begin
            exp_t e;
            e = res_q.pop_front();
            check_output("serial result", mon_sh, e.word);
            check_output("overflow at result", overflow, e.ovf);
          end
        end
      end
    end
  end

  task automatic shift_bits(input logic [DW-1:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      serial_load_enable = 1'b1;
      serial_data_in     = w[i];
      tick();
    end
    serial_load_enable = 1'b0;
    serial_data_in     = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " load_word"}, load_word, 0);
    check_output({tag, " load_word_valid"}, load_word_valid, 0);
    check_output({tag, " pe_start"}, pe_start, 0);
    check_output({tag, " busy"}, busy, 0);
    check_output({tag, " serial_data_out"}, serial_data_out, 0);
    check_output({tag, " serial_out_valid"}, serial_out_valid, 0);
    check_output({tag, " overflow"}, overflow, 0);
    check_output({tag, " computation_done"}, computation_done, 0);
  endtask

  // One full operation: done pulses at relative cycles d0..d3 (cycle 0 = start sampled).
  task automatic apply_stimulus(input logic [DW-1:0] p0, input logic [DW-1:0] p1,
                                input logic [DW-1:0] p2, input logic [DW-1:0] p3,
                                input logic byp, input int d0, input int d1, input int d2,
                                input int d3, input int extra_start,
                                input logic [DW-1:0] exp_word, input logic exp_ovf);
    int t0;
    int last;
    int n;
    last = d0;
    if (d1 > last) last = d1;
    if (d2 > last) last = d2;
    if (d3 > last) last = d3;
    pe_psum     = {p3, p2, p1, p0};
    relu_bypass = byp;
    res_q.push_back('{exp_word, exp_ovf});
    pe_start_cnt = 0;
    start_computation = 1'b1;
    t0 = cyc;
    for (int rel = 1; rel <= last; rel++) begin
      tick();
      start_computation = (rel == extra_start);
      pe_done = {d3 == rel, d2 == rel, d1 == rel, d0 == rel};
      if (rel == 1) begin
        check_output("pe_start after start", pe_start, 1);
        check_output("overflow cleared on start", overflow, 0);
        check_output("computation_done falls", computation_done, 0);
        check_output("busy in WAIT_PE", busy, 1);
      end
    end
    tick();
    pe_done = '0;
    start_computation = 1'b0;
    n = 0;
    while (!computation_done && n < 200) begin
      tick();
      n++;
    end
    if (!computation_done) begin
      tests++; fails++;
      $display("[TB] FAIL done timeout: got no computation_done, expected within 200 cycles");
    end else begin
      check_output("done latency from mask", cyc - (t0 + last), NP + DW + 2);
    end
    check_output("pe_start pulse count", pe_start_cnt, 1);
    check_output("overflow at done", overflow, exp_ovf);
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int bits;
    reset_n = 1'b0;
    serial_data_in = 1'b0;
    serial_load_enable = 1'b0;
    start_computation = 1'b0;
    relu_bypass = 1'b0;
    pe_done = '0;
    pe_psum = '0;
    #12;
    check_all_zero("reset");
    tick();
    reset_n = 1'b1;
    tick();

    // Deserialiser: full word, then a word split by an enable gap.
    lw_q.push_back(16'hA5C3);
    shift_bits(16'hA5C3, 15, 0);
    tick();
    check_output("load_word held", load_word, 16'hA5C3);
    lw_q.push_back(16'h1234);
    shift_bits(16'h1234, 15, 8);
    tick(); tick(); tick();
    check_output("no pulse during gap", lw_pulses, 1);
    shift_bits(16'h1234, 7, 0);
    tick();
    check_output("pulse count after split word", lw_pulses, 2);

    // Basic sum, ReLU on negative, bypass on negative.
    apply_stimulus(16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 2, 2, 2, 2, -1, 16'h000A, 1'b0);
    apply_stimulus(16'hFFFB, 16'd1, 16'd1, 16'd1, 1'b0, 2, 2, 2, 2, -1, 16'h0000, 1'b0);
    apply_stimulus(16'hFFFB, 16'd1, 16'd1, 16'd1, 1'b1, 2, 2, 2, 2, -1, 16'hFFFE, 1'b0);
    // Staggered single-cycle done pulses with an ignored mid-operation start.
    apply_stimulus(16'd10, 16'hFFFD, 16'd7, 16'd100, 1'b0, 3, 6, 5, 9, 7, 16'h0072, 1'b0);
    // Saturation both ways, then a clean run that must clear overflow.
    apply_stimulus(16'h7FFF, 16'h7FFF, 16'd0, 16'd0, 1'b0, 2, 2, 2, 2, -1, 16'h7FFF, 1'b1);
    apply_stimulus(16'h8000, 16'h8000, 16'd0, 16'd0, 1'b1, 2, 2, 2, 2, -1, 16'h8000, 1'b1);
    apply_stimulus(16'd1, 16'd1, 16'd1, 16'd1, 1'b0, 2, 2, 2, 2, -1, 16'h0004, 1'b0);

    // Asynchronous reset during the fifth output bit.
    pe_psum = {16'd4, 16'd3, 16'd2, 16'd1};
    relu_bypass = 1'b0;
    start_computation = 1'b1;
    tick();
    start_computation = 1'b0;
    tick();
    pe_done = '1;
    tick();
    pe_done = '0;
    n = 0;
    bits = 0;
    while (bits < 5 && n < 200) begin
      tick();
      n++;
      if (serial_out_valid) bits++;
    end
    check_output("reached fifth shift bit", bits, 5);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async reset");
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check_output("idle after reset busy", busy, 0);
    lw_q.push_back(16'hBEEF);
    shift_bits(16'hBEEF, 15, 0);
    tick();
    apply_stimulus(16'd5, 16'd6, 16'd7, 16'd8, 1'b0, 2, 2, 2, 2, -1, 16'h001A, 1'b0);

    tick(); tick();
    check_output("result queue drained", res_q.size(), 0);
    check_output("load queue drained", lw_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
